// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg -- shared definitions for the stopwatch controller.
//   sw_state_e          : FSM state encoding (also driven out on the debug/LED port)
//   DEB_CYCLES_DEFAULT  : default debounce qualification time in clk cycles
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } sw_state_e;

  // 10 ms at a 10 MHz clock
  localparam int DEB_CYCLES_DEFAULT = 100000;

endpackage

// File: rtl/stopwatch_btn_debounce.sv
// btn_debounce -- conditions one raw push-button into a single-cycle press pulse.
//   clk      : sole clock
//   rst      : synchronous active-high reset
//   btn_raw  : raw button level, asynchronous to clk
//   press    : one-cycle pulse per qualified 0->1 transition of the button
// Path: 2-flop synchronizer -> stability counter -> registered rising-edge detect.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  // The counter only ever reaches DEB_CYCLES-1 before it clears, so it cannot wrap.
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          hist_q, press_q, press_d;

  // After reset the button must first be seen released for DEB_CYCLES cycles
  // (armed). A button held through reset therefore never qualifies a press
  // until it is released and pressed again.
  always_comb begin
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    armed_d = armed_q;
    if (!armed_q) begin
      if (sync2_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        armed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (sync2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
    press_d = deb_q & ~hist_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      hist_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      hist_q  <= deb_q;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- two-button stopwatch control FSM.
//   clk, rst  : sole clock, synchronous active-high reset
//   btn_ss    : raw start/stop button
//   btn_lr    : raw lap/reset button
//   cnt_en    : counter-chain enable (RUN, LAP)
//   cnt_clr   : counter-chain clear request (IDLE)
//   lap_hold  : display freeze (LAP)
//   lap_load  : one-cycle display capture strobe on RUN->LAP entry
//   state     : current state code for debug/LEDs
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic       lap_load,
  output logic [1:0] state
);

  logic      ss_press, lr_press;
  sw_state_e state_q, state_d;
  logic      lap_load_q, lap_load_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_ss),
    .press   (ss_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lr (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_lr),
    .press   (lr_press)
  );

  // Start/stop is checked first in every state so it wins over a
  // coincident lap/reset press.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (ss_press) state_d = ST_RUN;
      ST_RUN: begin
        if (ss_press)      state_d = ST_STOP;
        else if (lr_press) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (ss_press)      state_d = ST_STOP;
        else if (lr_press) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (ss_press)      state_d = ST_RUN;
        else if (lr_press) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered alongside the state so it is high exactly in the first LAP cycle.
    lap_load_d = (state_q == ST_RUN) && (state_d == ST_LAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lap_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lap_load_q <= lap_load_d;
    end
  end

  assign cnt_en   = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign cnt_clr  = (state_q == ST_IDLE);
  assign lap_hold = (state_q == ST_LAP);
  assign lap_load = lap_load_q;
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       cnt_en, cnt_clr, lap_hold, lap_load;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  stopwatch_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_ss   (btn_ss),
    .btn_lr   (btn_lr),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .lap_hold (lap_hold),
    .lap_load (lap_load),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // A button level is "qualified" once the last DEB synchronized samples all
  // agree on the new value; the resulting press reaches the FSM two cycles later.
  // The FSM itself is a pair of transition tables with start/stop priority.
  int nxt_ss[4] = '{1, 3, 3, 1};
  int nxt_lr[4] = '{0, 2, 1, 0};
  bit m_s1[2], m_s2[2], m_deb[2], m_armed[2], m_d1[2], m_d2[2];
  bit m_win[2][$];
  int m_st = 0;
  bit m_ll = 1'b0;

  function automatic logic [7:0] model_vec();
    logic [1:0] s;
    s = 2'(m_st);
    return {2'b00, s, (m_st == 1 || m_st == 2), (m_st == 0), (m_st == 2), m_ll};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {2'b00, state, cnt_en, cnt_clr, lap_hold, lap_load};
  endfunction

  task automatic model_step();
    bit raw[2];
    bit p[2];
    int ones;
    int old;
    raw[0] = btn_ss;
    raw[1] = btn_lr;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_armed[b] = 0;
        m_d1[b] = 0; m_d2[b] = 0;
        m_win[b].delete();
      end
      m_st = 0;
      m_ll = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        bit rose;
        rose = 0;
        m_win[b].push_back(m_s2[b]);
        if (m_win[b].size() > DEB) void'(m_win[b].pop_front());
        if (m_win[b].size() == DEB) begin
          ones = 0;
          foreach (m_win[b][k]) ones += int'(m_win[b][k]);
          if (!m_armed[b]) begin
            if (ones == 0) m_armed[b] = 1;
          end else if (!m_deb[b] && ones == DEB) begin
            m_deb[b] = 1;
            rose = 1;
          end else if (m_deb[b] && ones == 0) begin
            m_deb[b] = 0;
          end
        end
        p[b] = m_d2[b];
        m_d2[b] = m_d1[b];
        m_d1[b] = rose;
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
      old = m_st;
      if (p[0])      m_st = nxt_ss[m_st];
      else if (p[1]) m_st = nxt_lr[m_st];
      m_ll = (old == 1 && m_st == 2);
    end
  endtask

  // One clock: model advances on the edge, DUT compared 2 time units later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
    check("cycle", dut_vec(), model_vec());
  endtask

  // Results of the most recent press() call
  int last_lat, last_ll, last_lap_seen, last_en_low;

  task automatic press(input bit ss, input bit lr, input string tag);
    logic [1:0] st0;
    st0 = state;
    last_lat = 0; last_ll = 0; last_lap_seen = 0; last_en_low = 0;
    btn_ss = ss;
    btn_lr = lr;
    for (int i = 1; i <= 22; i++) begin
      if (i == 13) begin
        btn_ss = 0;
        btn_lr = 0;
      end
      tick();
      if (last_lat == 0 && state !== st0) last_lat = i;
      if (lap_load) last_ll++;
      if (state == 2'b10) last_lap_seen++;
      if (!cnt_en) last_en_low++;
    end
    $display("press %-10s ss=%0d lr=%0d state %b->%b latency=%0d lap_load_cycles=%0d",
             tag, ss, lr, st0, state, last_lat, last_ll);
  endtask

  initial begin
    int nz;
    int hold;
    logic [1:0] st_before;

    // reset
    rst = 1;
    tick(); tick();
    check("reset_out", dut_vec(), 8'h04);
    rst = 0;
    for (int i = 0; i < 8; i++) tick();
    $display("reset     state=%b cnt_en=%0d cnt_clr=%0d", state, cnt_en, cnt_clr);

    // start
    press(1, 0, "ss_start");
    check("start_lat_7to8", 8'(last_lat >= 7 && last_lat <= 8), 8'h01);
    check("start_state", 8'(state), 8'h01);
    check("start_en_clr", {6'b0, cnt_en, cnt_clr}, 8'h02);

    // lap and back
    press(0, 1, "lr_lap");
    check("lap_state", 8'(state), 8'h02);
    check("lap_load_once", 8'(last_ll), 8'h01);
    check("lap_hold", 8'(lap_hold), 8'h01);
    check("lap_en_kept", 8'(last_en_low), 8'h00);
    press(0, 1, "lr_unlap");
    check("unlap_state", 8'(state), 8'h01);
    check("unlap_hold", 8'(lap_hold), 8'h00);
    check("unlap_en_kept", 8'(last_en_low), 8'h00);

    // stop, clear, restart
    press(1, 0, "ss_stop");
    check("stop_state", 8'(state), 8'h03);
    check("stop_en_clr", {6'b0, cnt_en, cnt_clr}, 8'h00);
    press(0, 1, "lr_clear");
    check("clear_state", 8'(state), 8'h00);
    check("clear_clr", 8'(cnt_clr), 8'h01);
    press(1, 0, "ss_restart");
    check("restart_state", 8'(state), 8'h01);

    // glitches shorter than the debounce time
    st_before = state;
    nz = 0;
    for (int g = 0; g < 5; g++) begin
      btn_ss = 1;
      for (int i = 0; i < 3; i++) begin tick(); if (state !== st_before) nz++; end
      btn_ss = 0;
      for (int i = 0; i < 3; i++) begin tick(); if (state !== st_before) nz++; end
    end
    for (int i = 0; i < 8; i++) begin tick(); if (state !== st_before) nz++; end
    $display("glitch    5 x 3-cycle pulses state=%b changes=%0d", state, nz);
    check("glitch_changes", 8'(nz), 8'h00);
    check("glitch_state", 8'(state), 8'h01);

    // simultaneous presses: start/stop wins
    press(1, 1, "both");
    check("both_state", 8'(state), 8'h03);
    check("both_no_lap", 8'(last_lap_seen), 8'h00);
    check("both_no_load", 8'(last_ll), 8'h00);

    // reset in LAP while start/stop is held
    press(1, 0, "ss_resume");
    press(0, 1, "lr_lap2");
    check("lap2_state", 8'(state), 8'h02);
    btn_ss = 1;
    tick();
    rst = 1;
    tick();
    check("midrst_out", dut_vec(), 8'h04);
    rst = 0;
    nz = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (state !== 2'b00) nz++; end
    check("held_no_run", 8'(nz), 8'h00);
    btn_ss = 0;
    for (int i = 0; i < 10; i++) tick();
    $display("midrst    held ss through reset, state=%b non_idle_cycles=%0d", state, nz);
    check("after_rst_state", 8'(state), 8'h00);
    press(1, 0, "ss_repress");
    check("repress_state", 8'(state), 8'h01);

    // randomized segments against the reference model
    for (int s = 0; s < 60; s++) begin
      btn_ss = 1'($urandom_range(0, 1));
      btn_lr = 1'($urandom_range(0, 1));
      rst    = ($urandom_range(0, 19) == 0);
      hold   = $urandom_range(1, 12);
      for (int i = 0; i < hold; i++) begin
        tick();
        rst = 0;
      end
      $display("rand %2d   ss=%0d lr=%0d hold=%2d state=%b", s, btn_ss, btn_lr, hold, state);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 100000, is the number of stable-input cycles for a debounce decision (10 ms at 10 MHz).
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 btn_ss  input  1  raw start/stop button, active-high, asynchronous to clk.
REQ-005 btn_lr  input  1  raw lap/reset button, active-high, asynchronous to clk.
REQ-006 cnt_en  output  1  counter-chain enable; high while timing.
REQ-007 cnt_clr  output  1  counter-chain clear request; counters honour it only while cnt_en=0.
REQ-008 lap_hold  output  1  display freeze; high while the lap value is shown.
REQ-009 lap_load  output  1  one-cycle strobe; display register captures the counter values.
REQ-010 state  output  2  current FSM state code, for debug and LEDs.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer, then a rising-edge detector that produces a one-cycle press pulse.
REQ-012 Debouncer: a counter runs while the synchronized level differs from the debounced level; any cycle of equality clears it; on reaching DEB_CYCLES the debounced level flips and the counter clears.
REQ-013 Press pulse SHALL be exactly one cycle per debounced 0->1 transition; release produces no pulse; a held button produces no repeat.
REQ-014 FSM states: IDLE=00, RUN=01, LAP=10, STOP=11.
REQ-015 IDLE: ss press -> RUN; lr press ignored.
REQ-016 RUN: ss press -> STOP; lr press -> LAP.
REQ-017 LAP: lr press -> RUN (display released); ss press -> STOP (display released, shows live stopped value).
REQ-018 STOP: ss press -> RUN (resume, no clear); lr press -> IDLE.
REQ-019 Simultaneous ss and lr pulses in the same cycle: ss SHALL take priority and lr is discarded.
REQ-020 The state register SHALL update on the edge that samples the press pulse; cnt_en, cnt_clr, lap_hold and state SHALL be Moore decodes of the state register, valid in the same cycle as the new state.
REQ-021 Decodes: cnt_en=1 in RUN and LAP; cnt_clr=1 in IDLE only; lap_hold=1 in LAP only.
REQ-022 lap_load SHALL be high for exactly the first cycle in LAP (RUN->LAP entry) and low otherwise.
REQ-023 Counting SHALL continue uninterrupted through RUN<->LAP transitions; cnt_en does not drop.
REQ-024 Latency from a raw button rising edge held stable to the state change SHALL be DEB_CYCLES+3 to DEB_CYCLES+4 cycles (synchronizer, debounce, edge detect).
REQ-025 Glitches shorter than DEB_CYCLES cycles SHALL produce no pulse and no state change.

Reset
REQ-026 While rst=1 at posedge clk: state=IDLE, synchronizer flops=0, debounced levels=0, debounce counters=0, edge-detect history=0.
REQ-027 Output values during and after reset: cnt_en=0, cnt_clr=1, lap_hold=0, lap_load=0, state=00.
REQ-028 Reset asserted mid-operation (any state, mid-debounce) SHALL abort everything within that cycle; a button held through reset release SHALL NOT generate a press until it is released and pressed again, because the debounced level restarts at 0 and must first re-qualify high.

Structure
REQ-029 Shared package stopwatch_pkg SHALL hold the state encoding typedef (IDLE/RUN/LAP/STOP) and the DEB_CYCLES default constant.
REQ-030 Sub-module btn_debounce (synchronizer, debounce counter, edge pulse; parameter DEB_CYCLES) SHALL be instantiated once per button.
REQ-031 The debounce counter width SHALL be sized from DEB_CYCLES, and the counter SHALL NOT wrap.

Verification (DEB_CYCLES=4)
REQ-032 Reset, then btn_ss held high for 10 cycles -> exactly one ss pulse; state 00->01 within 7-8 cycles of the rise; cnt_en=1, cnt_clr=0.
REQ-033 In RUN, btn_lr pressed -> state 10; lap_load=1 for one cycle; lap_hold=1; cnt_en stays 1. Second lr press -> state 01, lap_hold=0.
REQ-034 In RUN, ss press -> STOP (cnt_en=0, cnt_clr=0); lr press -> IDLE (cnt_clr=1); ss press -> RUN.
REQ-035 btn_ss pulsed high for 3 cycles, repeated 5 times with gaps -> no press pulse, state unchanged.
REQ-036 In RUN, btn_ss and btn_lr rise on the same cycle and are held -> state STOP (11), never LAP; lap_load stays 0.
REQ-037 In LAP, rst=1 for 1 cycle while btn_ss is held -> state 00, outputs at reset values; no RUN entry until btn_ss is released and re-pressed.
